// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns raw PS/2 keyboard clock/data lines into 11-bit key
// event words. The lines are synchronised, the clock is de-glitched, and
// 11-bit frames are deserialised and checked. Accepted bytes are then folded
// into E0/F0 prefix flags, a Pause skip counter, or a toggled key event.
module ps2_key_decoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int              WD_W      = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT  = WD_W'(TIMEOUT);
  localparam logic [7:0]      FILT_LAST = 8'(FILTER_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers: bit 0 is the PS/2 clock, bit 1 is the PS/2 data
  // ---------------------------------------------------------------------------
  logic [1:0] line_raw;
  logic [1:0] line_sync;

  assign line_raw = {ps2_data, ps2_clk};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic s1_reg;
      logic s2_reg;

      // Two-flop synchroniser; both stages idle high like the bus
      always_ff @(posedge clk_sys) begin
        if (reset) begin
          s1_reg <= 1'b1;
          s2_reg <= 1'b1;
        end else begin
          s1_reg <= line_raw[gi];
          s2_reg <= s1_reg;
        end
      end

      assign line_sync[gi] = s2_reg;
    end
  endgenerate

  logic clk_s;
  logic data_s;

  assign clk_s  = line_sync[0];
  assign data_s = line_sync[1];

  // ---------------------------------------------------------------------------
  // Clock glitch filter and falling-edge detector
  // ---------------------------------------------------------------------------
  logic       clk_f_reg;
  logic       clk_f_d_reg;
  logic [7:0] filt_cnt_reg;
  logic       fall;

  // clk_f follows clk_s only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_f_reg    <= 1'b1;
      clk_f_d_reg  <= 1'b1;
      filt_cnt_reg <= 8'd0;
    end else begin
      clk_f_d_reg <= clk_f_reg;
      if (clk_s == clk_f_reg) begin
        filt_cnt_reg <= 8'd0;
      end else if (filt_cnt_reg == FILT_LAST) begin
        clk_f_reg    <= clk_s;
        filt_cnt_reg <= 8'd0;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + 8'd1;
      end
    end
  end

  assign fall = clk_f_d_reg & ~clk_f_reg;

  // ---------------------------------------------------------------------------
  // Frame FSM with watchdog
  // ---------------------------------------------------------------------------
  state_t          state_reg,   state_next;
  logic [2:0]      bit_cnt_reg, bit_cnt_next;
  logic [7:0]      shift_reg,   shift_next;
  logic            parity_reg,  parity_next;
  logic [WD_W-1:0] wd_reg,      wd_next;
  logic            byte_ok;
  logic            byte_bad;

  // Frame state register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      bit_cnt_reg <= 3'd0;
      shift_reg   <= 8'd0;
      parity_reg  <= 1'b0;
      wd_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      parity_reg  <= parity_next;
      wd_reg      <= wd_next;
    end
  end

  // Next-state logic; a watchdog expiry takes priority over a coincident edge
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    parity_next  = parity_reg;
    wd_next      = (state_reg == S_IDLE || fall) ? '0 : wd_reg + 1'b1;
    byte_ok      = 1'b0;
    byte_bad     = 1'b0;

    if (state_reg != S_IDLE && wd_reg == WD_LIMIT) begin
      state_next = S_IDLE;
      wd_next    = '0;
      byte_bad   = 1'b1;
    end else if (fall) begin
      case (state_reg)
        S_IDLE: begin
          // A high data line at a falling edge is a glitch, not a start bit
          if (!data_s) begin
            state_next   = S_DATA;
            bit_cnt_next = 3'd0;
          end
        end
        S_DATA: begin
          shift_next   = {data_s, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            state_next = S_PARITY;
          end
        end
        S_PARITY: begin
          parity_next = data_s;
          state_next  = S_STOP;
        end
        S_STOP: begin
          state_next = S_IDLE;
          if (data_s && (^{shift_reg, parity_reg})) begin
            byte_ok = 1'b1;
          end else begin
            byte_bad = 1'b1;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Byte interpretation
  // ---------------------------------------------------------------------------
  logic        ext_reg,  ext_next;
  logic        rel_reg,  rel_next;
  logic [2:0]  skip_reg, skip_next;
  logic [10:0] key_reg,  key_next;
  logic        err_reg;

  // Prefix flags, Pause skip counter, key word and error pulse
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ext_reg  <= 1'b0;
      rel_reg  <= 1'b0;
      skip_reg <= 3'd0;
      key_reg  <= 11'd0;
      err_reg  <= 1'b0;
    end else begin
      ext_reg  <= ext_next;
      rel_reg  <= rel_next;
      skip_reg <= skip_next;
      key_reg  <= key_next;
      err_reg  <= byte_bad;
    end
  end

  // Decide what an accepted byte means; errors only drop the prefix flags
  always_comb begin
    ext_next  = ext_reg;
    rel_next  = rel_reg;
    skip_next = skip_reg;
    key_next  = key_reg;

    if (byte_bad) begin
      ext_next = 1'b0;
      rel_next = 1'b0;
    end else if (byte_ok) begin
      if (skip_reg != 3'd0) begin
        // Inside the Pause sequence: swallow the byte without side effects
        skip_next = skip_reg - 3'd1;
      end else begin
        case (shift_reg)
          8'hE0: ext_next  = 1'b1;
          8'hF0: rel_next  = 1'b1;
          8'hE1: skip_next = 3'd7;
          8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: begin
            ext_next = 1'b0;
            rel_next = 1'b0;
          end
          default: begin
            key_next = {~key_reg[10], ~rel_reg, ext_reg, shift_reg};
            ext_next = 1'b0;
            rel_next = 1'b0;
          end
        endcase
      end
    end
  end

  assign ps2_key   = key_reg;
  assign frame_err = err_reg;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed test-plan sequences plus
// randomised frames, scored against a byte-level reference model.
module tb_ps2_key_decoder;

  localparam int FL   = 4;
  localparam int TO   = 600;
  localparam int HALF = 25;

  logic        clk_sys  = 1'b0;
  logic        reset    = 1'b1;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  logic [10:0] exp_q[$];
  int          err_pending = 0;

  // reference model state
  bit m_tog;
  bit m_ext;
  bit m_rel;
  int m_skip;

  always #5 clk_sys = ~clk_sys;

  ps2_key_decoder #(
    .FILTER_LEN(FL),
    .TIMEOUT   (TO)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ps2_key  (ps2_key),
    .frame_err(frame_err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #2;
    end
  endtask

  task automatic model_reset();
    m_tog  = 1'b0;
    m_ext  = 1'b0;
    m_rel  = 1'b0;
    m_skip = 0;
  endtask

  // What the keyboard block should see for one received byte
  task automatic model_byte(input logic [7:0] b, input bit good);
    if (!good) begin
      m_ext = 1'b0;
      m_rel = 1'b0;
      err_pending++;
    end else if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_rel = 1'b1;
    end else if (b == 8'hE1) begin
      m_skip = 7;
    end else if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF}) begin
      m_ext = 1'b0;
      m_rel = 1'b0;
    end else begin
      m_tog = ~m_tog;
      exp_q.push_back({m_tog, ~m_rel, m_ext, b});
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endtask

  // One PS/2 bit: data set while the clock is high, then a full low phase
  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  // kind: 0 good, 1 bad parity, 2 bad stop bit
  task automatic send_frame(input logic [7:0] b, input int kind);
    logic par;
    par = ~(^b);
    if (kind == 1) par = ~par;
    model_byte(b, kind == 0);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(kind == 2 ? 1'b0 : 1'b1);
    ps2_data = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  // Scoreboard monitor: compares every ps2_key change and frame_err pulse
  initial begin
    logic [10:0] prev_key;
    logic [10:0] exp_key;
    logic        err_prev;
    prev_key = 11'd0;
    err_prev = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (reset) begin
        prev_key = ps2_key;
        err_prev = 1'b0;
      end else begin
        if (ps2_key !== prev_key) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_key got %03h expected no update", ps2_key);
          end else begin
            exp_key = exp_q.pop_front();
            $display("key event %03h expected %03h", ps2_key, exp_key);
            check("key_event", {21'd0, ps2_key}, {21'd0, exp_key});
          end
          prev_key = ps2_key;
        end
        if (frame_err === 1'b1) begin
          $display("frame_err pulse, errors pending %0d", err_pending);
          checks++;
          if (err_pending == 0) begin
            errors++;
            $display("FAIL unexpected_frame_err got 1 expected 0");
          end else begin
            err_pending--;
          end
          if (err_prev) begin
            errors++;
            $display("FAIL frame_err_width got 2+ cycles expected 1");
          end
        end
        err_prev = frame_err;
      end
    end
  end

  // Global time bound
  initial begin
    #3ms;
    $display("FAIL global_timeout got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  logic [7:0] ign[7] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
  logic [7:0] pause_seq[8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

  initial begin
    logic [7:0] tbyte;
    int         n;
    bit         seen;
    int         r;
    int         kind;

    model_reset();
    #2;
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(2);
    check("reset_key", {21'd0, ps2_key}, 32'h0);
    check("reset_err", {31'd0, frame_err}, 32'h0);

    // Make, break, extended make, extended break
    send_frame(8'h1C, 0);
    check("make_1c", {21'd0, ps2_key}, 32'h61C);
    send_frame(8'hF0, 0);
    check("no_update_after_f0", {21'd0, ps2_key}, 32'h61C);
    send_frame(8'h1C, 0);
    check("break_1c", {21'd0, ps2_key}, 32'h01C);
    send_frame(8'hE0, 0);
    send_frame(8'h75, 0);
    check("ext_make_75", {21'd0, ps2_key}, 32'h775);
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h75, 0);
    check("ext_break_75", {21'd0, ps2_key}, 32'h175);

    // Parity error, then a good byte
    send_frame(8'h1C, 1);
    check("parity_err_key_hold", {21'd0, ps2_key}, 32'h175);
    send_frame(8'h1B, 0);
    check("after_parity_err", {21'd0, ps2_key}, 32'h61B);

    // Stop after 4 data bits and time the watchdog pulse
    model_byte(8'h00, 1'b0);
    tbyte = 8'h5A;
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(tbyte[i]);
    ps2_data = tbyte[3];
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    n = 0;
    seen = 1'b0;
    while (n < TO + 200 && !seen) begin
      @(negedge clk_sys);
      n++;
      if (frame_err === 1'b1) seen = 1'b1;
    end
    check("timeout_seen", {31'd0, seen}, 32'h1);
    checks++;
    if (n < 4 + FL + TO || n > 6 + FL + TO) begin
      errors++;
      $display("FAIL timeout_delay got %0d expected %0d", n, 5 + FL + TO);
    end
    wait_cyc(1);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(2 * HALF);
    send_frame(8'h22, 0);
    check("after_timeout", {21'd0, ps2_key}, 32'h222);

    // Short low glitch on the clock while data is low must not start a frame
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    wait_cyc(FL - 1);
    ps2_clk = 1'b1;
    wait_cyc(20);
    ps2_data = 1'b1;
    wait_cyc(20);
    send_frame(8'h1C, 0);
    check("after_glitch", {21'd0, ps2_key}, 32'h61C);

    // Pause sequence produces nothing
    for (int i = 0; i < 8; i++) send_frame(pause_seq[i], 0);
    check("pause_no_change", {21'd0, ps2_key}, 32'h61C);

    // Reset mid-frame after 5 bits
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    model_reset();
    wait_cyc(2 * HALF);
    check("mid_reset_key", {21'd0, ps2_key}, 32'h0);
    send_frame(8'h2A, 0);
    check("fresh_after_reset", {21'd0, ps2_key}, 32'h62A);

    // Randomised traffic
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 19);
      if (r < 3)       tbyte = 8'hE0;
      else if (r < 6)  tbyte = 8'hF0;
      else if (r < 8)  tbyte = ign[$urandom_range(0, 6)];
      else if (r == 8) tbyte = 8'hE1;
      else             tbyte = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 9);
      kind = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
      send_frame(tbyte, kind);
    end

    wait_cyc(100);
    check("expected_queue_empty", 32'(exp_q.size()), 32'h0);
    check("errors_all_seen", 32'(err_pending), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
